// File: rtl/ising_pkg.sv
// ============================================================================
// Module : ising_pkg
// Brief  : Shared FSM encodings and settle length for the spin readout block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ising_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Cycles spent flushing the synchronizers before counting begins.
    localparam int c_settle_cycles = 2;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer for one asynchronous bit, synchronous active-low reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/spin_readout.sv
// ============================================================================
// Module : spin_readout
// Brief  : Phase-mismatch counter over a fixed window; decides one spin per
//          oscillator. Define SPIN_READOUT_COUNTS_EN to expose raw counts.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spin_readout
    import ising_pkg::*;
#(
    parameter  int NUM_SPINS = 8,
    parameter  int WINDOW    = 256,
    localparam int CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    output logic                       busy,
    input  logic                       ref_in,
    input  logic [NUM_SPINS-1:0]       osc_in,
    output logic                       spins_valid,
    input  logic                       spins_ready,
`ifdef SPIN_READOUT_COUNTS_EN
    output logic [NUM_SPINS*CNT_W-1:0] counts,
`endif
    output logic [NUM_SPINS-1:0]       spins
);

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(c_settle_cycles - 1);
    localparam logic [CNT_W-1:0] c_window_last = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_half        = CNT_W'(WINDOW / 2);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_phase;
    logic [CNT_W-1:0]       r_cnt [NUM_SPINS];
    logic [NUM_SPINS-1:0]   r_spins;

    logic                   w_sync_ref;
    logic [NUM_SPINS-1:0]   w_sync_osc;
    logic [NUM_SPINS-1:0]   w_mis;
    logic [CNT_W-1:0]       w_next [NUM_SPINS];
    logic [NUM_SPINS-1:0]   w_spins_next;
    logic                   w_last_count;

    sync_2ff u_sync_ref (
        .clk  (clk),
        .rstn (rstn),
        .d    (ref_in),
        .q    (w_sync_ref)
    );

    generate
        for (genvar gi = 0; gi < NUM_SPINS; gi++) begin : g_sync_osc
            sync_2ff u_sync (
                .clk  (clk),
                .rstn (rstn),
                .d    (osc_in[gi]),
                .q    (w_sync_osc[gi])
            );
        end
    endgenerate

    assign w_mis        = w_sync_osc ^ {NUM_SPINS{w_sync_ref}};
    assign w_last_count = (r_state == COUNT) && (r_phase == c_window_last);

    // The decision uses the count including the final window sample.
    always_comb begin
        for (int i = 0; i < NUM_SPINS; i++) begin
            w_next[i]       = r_cnt[i] + CNT_W'(w_mis[i]);
            w_spins_next[i] = (w_next[i] > c_half);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_spins <= '0;
            for (int i = 0; i < NUM_SPINS; i++) r_cnt[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SETTLE;
                        r_phase <= '0;
                        for (int i = 0; i < NUM_SPINS; i++) r_cnt[i] <= '0;
                    end
                end
                SETTLE: begin
                    if (r_phase == c_settle_last) begin
                        r_state <= COUNT;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                COUNT: begin
                    for (int i = 0; i < NUM_SPINS; i++) r_cnt[i] <= w_next[i];
                    if (w_last_count) begin
                        r_state <= DONE;
                        r_spins <= w_spins_next;
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (spins_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPIN_READOUT_COUNTS_EN
    logic [NUM_SPINS*CNT_W-1:0] r_counts;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_counts <= '0;
        end else if (w_last_count) begin
            for (int i = 0; i < NUM_SPINS; i++) r_counts[i*CNT_W +: CNT_W] <= w_next[i];
        end
    end

    assign counts = r_counts;
`endif

    assign busy        = (r_state != IDLE);
    assign spins_valid = (r_state == DONE);
    assign spins       = r_spins;

endmodule

`default_nettype wire

// File: tb/tb_spin_readout.sv
// ============================================================================
// Module : tb_spin_readout
// Brief  : Self-checking bench: directed scenarios plus randomized windows
//          against a window-sum reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spin_readout;

    localparam int c_n  = 3;
    localparam int c_w  = 16;
    localparam int c_cw = $clog2(c_w + 1);

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            busy;
    logic            ref_in;
    logic [c_n-1:0]  osc_in;
    logic            spins_valid;
    logic            spins_ready;
    logic [c_n-1:0]  spins;
`ifdef SPIN_READOUT_COUNTS_EN
    logic [c_n*c_cw-1:0] counts;
`endif

    spin_readout #(.NUM_SPINS(c_n), .WINDOW(c_w)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .busy        (busy),
        .ref_in      (ref_in),
        .osc_in      (osc_in),
        .spins_valid (spins_valid),
        .spins_ready (spins_ready),
`ifdef SPIN_READOUT_COUNTS_EN
        .counts      (counts),
`endif
        .spins       (spins)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [c_n-1:0]  osc_seq [0:c_w+2];
    logic            ref_seq [0:c_w+2];
    logic [c_n-1:0]  exp_spins;
    logic [c_n*c_cw-1:0] exp_counts;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the window is the c_w input samples taken on the edges right
    // after the start edge; a spin is 1 when strictly more than half mismatch.
    task automatic model();
        int c;
        for (int i = 0; i < c_n; i++) begin
            c = 0;
            for (int k = 1; k <= c_w; k++) c += int'(osc_seq[k][i] ^ ref_seq[k]);
            exp_spins[i] = (2 * c > c_w);
            exp_counts[i*c_cw +: c_cw] = c_cw'(c);
        end
    endtask

    task automatic check_counts(input string tag);
`ifdef SPIN_READOUT_COUNTS_EN
        check(tag, 64'(counts), 64'(exp_counts));
`endif
    endtask

    // Full measurement: start sampled at edge E0, valid expected after edge E0+c_w+2.
    task automatic measure(input int hold, input bit extra);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int k = 1; k <= c_w + 2; k++) begin
            start  = extra && (k == 5);
            osc_in = osc_seq[k];
            ref_in = ref_seq[k];
            @(posedge clk); #1;
            start = 1'b0;
            if (k <= c_w + 1) check("valid_early", 64'(spins_valid), 64'd0);
            check("busy_measuring", 64'(busy), 64'd1);
        end
        check("valid_on_time", 64'(spins_valid), 64'd1);
        check("spins", 64'(spins), 64'(exp_spins));
        check_counts("counts");
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("valid_held", 64'(spins_valid), 64'd1);
            check("spins_held", 64'(spins), 64'(exp_spins));
            check_counts("counts_held");
        end
        spins_ready = 1'b1;
        start       = extra;
        @(posedge clk); #1;
        spins_ready = 1'b0;
        start       = 1'b0;
        check("valid_after_hs", 64'(spins_valid), 64'd0);
        check("busy_after_hs", 64'(busy), 64'd0);
        check("spins_kept_idle", 64'(spins), 64'(exp_spins));
        @(posedge clk); #1;
        check("no_second_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; spins_ready = 1'b0; ref_in = 1'b0; osc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(spins_valid), 64'd0);
        check("rst_spins", 64'(spins), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Toggling spin2 ties at half the window; spin1 always matches, spin0 never.
        for (int k = 0; k <= c_w + 2; k++) begin
            osc_seq[k] = {k[0], 1'b0, 1'b1};
            ref_seq[k] = 1'b0;
        end
        model();
        check("s1_model_spins", 64'(exp_spins), 64'(3'b001));
        measure(10, 1'b1);

        // Abort mid-COUNT with reset.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            osc_in = c_n'($urandom);
            ref_in = 1'($urandom);
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(spins_valid), 64'd0);
        check("abort_spins", 64'(spins), 64'd0);
        exp_counts = '0;
        check_counts("abort_counts");
        repeat (c_w + 4) @(posedge clk);
        #1;
        check("abort_no_result", 64'(spins_valid), 64'd0);
        for (int k = 0; k <= c_w + 2; k++) begin
            osc_seq[k] = c_n'($urandom);
            ref_seq[k] = 1'($urandom);
        end
        model();
        measure(1, 1'b0);

        // Constant patterns against ref=1, then complementary pattern.
        for (int k = 0; k <= c_w + 2; k++) begin
            osc_seq[k] = 3'b110;
            ref_seq[k] = 1'b1;
        end
        model();
        measure(0, 1'b0);
        check("s5_first", 64'(spins), 64'(3'b001));
        repeat (3) @(posedge clk);
        #1;
        check("s5_held_idle", 64'(spins), 64'(3'b001));
        for (int k = 0; k <= c_w + 2; k++) osc_seq[k] = 3'b001;
        model();
        measure(2, 1'b0);
        check("s5_second", 64'(spins), 64'(3'b110));

        // Randomized windows; odd runs bias towards clear decisions.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k <= c_w + 2; k++) begin
                ref_seq[k] = 1'($urandom);
                osc_seq[k] = (r % 2 == 1) ? (($urandom_range(0, 3) == 0) ? c_n'($urandom)
                                                                         : {c_n{ref_seq[k] ^ r[1]}})
                                          : c_n'($urandom);
            end
            model();
            measure(int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
